// File: rtl/shift_pkg.sv
// shift_pkg: request/core op encodings, execute-unit states and the request-to-core op map.
package shift_pkg;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [1:0] BS_SLL = 2'b01;
    localparam logic [1:0] BS_SRA = 2'b10;
    localparam logic [1:0] BS_SRL = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_PASS1, ST_PASS2} state_e;
    // ROR starts with a logical right shift, so it shares the SRL core code
    function automatic logic [1:0] bs_map(input logic [1:0] op);
        return op == OP_SLL ? BS_SLL : op == OP_SRA ? BS_SRA : BS_SRL;
    endfunction
endpackage

// File: rtl/shift_exec_unit_barrel.sv
// BarrelShift: combinational 16-bit shifter core; code 00 passes the value through.
module BarrelShift
    import shift_pkg::*;
(
    input  logic [15:0] i_value,
    input  logic [3:0]  i_count,
    input  logic [1:0]  i_op,
    output logic [15:0] o_result
);
    logic signed [15:0] sra;
    always_comb begin
        sra      = $signed(i_value) >>> i_count;
        o_result = i_op == BS_SLL ? i_value << i_count :
                   i_op == BS_SRA ? sra :
                   i_op == BS_SRL ? i_value >> i_count : i_value;
    end
endmodule

// File: rtl/shift_exec_unit.sv
// shift_exec_unit: registered execute stage sequencing shift/rotate requests through one BarrelShift.
module shift_exec_unit
    import shift_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_flush,
    input  logic             i_reqValid,
    output logic             o_reqReady,
    input  logic [15:0]      i_reqValue,
    input  logic [3:0]       i_reqCount,
    input  logic [1:0]       i_reqOp,
    input  logic [TAG_W-1:0] i_reqTag,
    output logic             o_rspValid,
    input  logic             i_rspReady,
    output logic [15:0]      o_rspResult,
    output logic [TAG_W-1:0] o_rspTag,
    output logic             o_rspZero
);
    state_e state_q, state_d;
    logic [15:0] val_q, val_d, part_q, part_d, res_q, res_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d, rtag_q, rtag_d;
    logic vld_q, vld_d, zero_q, zero_d;
    logic [15:0] core_out, final_res;
    logic [3:0] core_cnt;
    logic [1:0] core_op;
    logic accept, load, ror_first;

    BarrelShift u_core (
        .i_value (val_q),
        .i_count (core_cnt),
        .i_op    (core_op),
        .o_result(core_out)
    );

    always_comb begin
        accept    = state_q == ST_IDLE && i_reqValid && !i_flush;
        ror_first = state_q == ST_PASS1 && op_q == OP_ROR;
        // second rotate pass shifts left by the 4-bit two's complement of n
        core_op   = state_q == ST_PASS2 ? BS_SLL : bs_map(op_q);
        core_cnt  = state_q == ST_PASS2 ? 4'd0 - cnt_q : cnt_q;
        final_res = state_q == ST_PASS2 ? part_q | core_out : core_out;
        load      = !i_flush && (!vld_q || i_rspReady) &&
                    ((state_q == ST_PASS1 && op_q != OP_ROR) || state_q == ST_PASS2);
        state_d   = i_flush ? ST_IDLE : accept ? ST_PASS1 : load ? ST_IDLE :
                    ror_first ? ST_PASS2 : state_q;
        val_d     = accept ? i_reqValue : val_q;
        cnt_d     = accept ? i_reqCount : cnt_q;
        op_d      = accept ? i_reqOp : op_q;
        tag_d     = accept ? i_reqTag : tag_q;
        part_d    = ror_first ? core_out : part_q;
        vld_d     = i_flush ? 1'b0 : load ? 1'b1 : i_rspReady ? 1'b0 : vld_q;
        res_d     = load ? final_res : res_q;
        rtag_d    = load ? tag_q : rtag_q;
        zero_d    = load ? final_res == 16'd0 : zero_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            part_q  <= '0;
            vld_q   <= 1'b0;
            res_q   <= '0;
            rtag_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            part_q  <= part_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            rtag_q  <= rtag_d;
            zero_q  <= zero_d;
        end
    end

    assign o_reqReady  = state_q == ST_IDLE;
    assign o_rspValid  = vld_q;
    assign o_rspResult = res_q;
    assign o_rspTag    = rtag_q;
    assign o_rspZero   = zero_q;
endmodule

// File: tb/tb_shift_exec_unit.sv
// tb_shift_exec_unit: directed stimulus with an in-order scoreboard fed by an arithmetic shift model.
module tb_shift_exec_unit;
    logic clk = 1'b0, rstn = 1'b1, flush = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
    logic [15:0] req_value = '0;
    logic [3:0] req_count = '0;
    logic [1:0] req_op = '0;
    logic [2:0] req_tag = '0;
    logic req_ready, rsp_valid, rsp_zero;
    logic [15:0] rsp_result;
    logic [2:0] rsp_tag;
    int cmps = 0, errs = 0;
    logic [18:0] exp_q[$];

    shift_exec_unit #(.TAG_W(3)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush),
        .i_reqValid(req_valid), .o_reqReady(req_ready),
        .i_reqValue(req_value), .i_reqCount(req_count), .i_reqOp(req_op), .i_reqTag(req_tag),
        .o_rspValid(rsp_valid), .i_rspReady(rsp_ready),
        .o_rspResult(rsp_result), .o_rspTag(rsp_tag), .o_rspZero(rsp_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] v, input logic [3:0] c, input logic [1:0] op);
        logic [31:0] vv;
        vv = {v, v} >> c;
        case (op)
            2'b00:   return v << c;
            2'b01:   return (v >> c) | (v[15] ? ~(16'hFFFF >> c) : 16'h0000);
            2'b10:   return v >> c;
            default: return vv[15:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmps++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: push on accept, compare on every response handshake, drop all on flush/reset
    always @(negedge clk) begin
        if (!rstn || flush) exp_q.delete();
        else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    logic [18:0] e;
                    e = exp_q.pop_front();
                    chk("sb_result", rsp_result, e[15:0]);
                    chk("sb_tag", rsp_tag, e[18:16]);
                    chk("sb_zero", rsp_zero, e[15:0] == 16'd0);
                end
            end
            if (req_valid && req_ready) exp_q.push_back({req_tag, model(req_value, req_count, req_op)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] c, input logic [1:0] op, input logic [2:0] t);
        req_value = v; req_count = c; req_op = op; req_tag = t; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                step();
                req_valid = 1'b0;
                return;
            end
            step();
        end
        req_valid = 1'b0;
        chk("accept_timeout", 0, 1);
    endtask

    task automatic run_one(input logic [15:0] v, input logic [3:0] c, input logic [1:0] op,
                           input logic [2:0] t, input logic [15:0] exp);
        send(v, c, op, t);
        chk("lat_valid_early", rsp_valid, 0);
        if (op == 2'b11) begin
            step();
            chk("ror_valid_early", rsp_valid, 0);
        end
        step();
        chk("lat_valid", rsp_valid, 1);
        chk("lat_result", rsp_result, exp);
        chk("lat_tag", rsp_tag, t);
        chk("lat_zero", rsp_zero, exp == 16'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_zero", rsp_zero, 0);
        chk("rst_ready", req_ready, 1);
        step();
        rstn = 1'b1;
        chk("model_sll", model(16'h8001, 1, 2'b00), 16'h0002);
        chk("model_sra", model(16'h8000, 15, 2'b01), 16'hFFFF);
        chk("model_ror4", model(16'h1234, 4, 2'b11), 16'h4123);
        chk("model_ror1", model(16'h0001, 1, 2'b11), 16'h8000);
        rsp_ready = 1'b1;
        run_one(16'h8001, 1, 2'b00, 5, 16'h0002);
        run_one(16'h00A5, 0, 2'b00, 1, 16'h00A5);
        run_one(16'h8000, 15, 2'b01, 2, 16'hFFFF);
        run_one(16'h8000, 15, 2'b10, 3, 16'h0001);
        run_one(16'h0001, 1, 2'b10, 4, 16'h0000);
        run_one(16'h1234, 4, 2'b11, 6, 16'h4123);
        run_one(16'h1234, 0, 2'b11, 7, 16'h1234);
        run_one(16'h0001, 1, 2'b11, 0, 16'h8000);
        // backpressure: second request stalls in its final pass behind a held response
        rsp_ready = 1'b0;
        send(16'h0F0F, 4, 2'b00, 1);
        send(16'hF000, 8, 2'b10, 2);
        chk("bp_ready", req_ready, 0);
        step();
        step();
        chk("bp_ready_hold", req_ready, 0);
        chk("bp_valid", rsp_valid, 1);
        chk("bp_result_stable", rsp_result, 16'hF0F0);
        chk("bp_tag_stable", rsp_tag, 1);
        rsp_ready = 1'b1;
        step();
        chk("bp_second_valid", rsp_valid, 1);
        chk("bp_second_result", rsp_result, 16'h00F0);
        chk("bp_second_tag", rsp_tag, 2);
        step();
        chk("bp_drained", rsp_valid, 0);
        chk("bp_sb_empty", exp_q.size(), 0);
        // flush during PASS2 of a rotate with a held response
        rsp_ready = 1'b0;
        send(16'h0003, 1, 2'b00, 3);
        send(16'h00FF, 4, 2'b11, 4);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", rsp_valid, 0);
        chk("flush_ready", req_ready, 1);
        rsp_ready = 1'b1;
        step();
        step();
        step();
        chk("flush_no_rsp", rsp_valid, 0);
        req_value = 16'h0101; req_count = 1; req_op = 2'b00; req_tag = 5;
        req_valid = 1'b1;
        flush = 1'b1;
        step();
        req_valid = 1'b0;
        flush = 1'b0;
        chk("flush_req_ready", req_ready, 1);
        step();
        chk("flush_req_no_rsp", rsp_valid, 0);
        // asynchronous reset mid-rotate with a held response
        rsp_ready = 1'b0;
        send(16'h1111, 1, 2'b00, 6);
        send(16'hABCD, 8, 2'b11, 7);
        chk("pre_rst_valid", rsp_valid, 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_result", rsp_result, 0);
        chk("mid_rst_tag", rsp_tag, 0);
        chk("mid_rst_zero", rsp_zero, 0);
        chk("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        step();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        run_one(16'hABCD, 8, 2'b11, 7, 16'hCDAB);
        step();
        chk("end_sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
